// File: rtl/sdrd_byte_assembler.sv
// ============================================================================
// Module   : sdrd_byte_assembler
// Purpose  : Assembles SDRD serial bits (LSB first) into words and buffers
//            them in a small FIFO drained by a valid/ready consumer.
// Options  : `define SDRD_PARITY_CHECK_EN adds a trailing odd-parity sample
//            per word and a parity_err pulse output.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module sdrd_byte_assembler #(
   parameter int WIDTH        = 8,
   parameter int FIFO_DEPTH   = 4,
   parameter int IDLE_TIMEOUT = 255
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     sser_n,
   input  logic                     ba13,
   input  logic                     ba12,
   input  logic                     br_w,
   input  logic                     bus_strobe,
   input  logic                     sdrd,
   input  logic                     frame_clr,
   output logic [WIDTH-1:0]         out_data,
   output logic                     out_valid,
   input  logic                     out_ready,
`ifdef SDRD_PARITY_CHECK_EN
   output logic [$clog2(WIDTH+2)-1:0] bit_cnt,
   output logic                     parity_err,
`else
   output logic [$clog2(WIDTH+1)-1:0] bit_cnt,
`endif
   output logic                     overflow,
   output logic                     timeout_evt
);

`ifdef SDRD_PARITY_CHECK_EN
   localparam int CNT_W = $clog2(WIDTH + 2);
   localparam int C_LAST_IDX = WIDTH;
`else
   localparam int CNT_W = $clog2(WIDTH + 1);
   localparam int C_LAST_IDX = WIDTH - 1;
`endif
   localparam int AW = $clog2(FIFO_DEPTH);
   localparam logic [CNT_W-1:0] c_last   = CNT_W'(C_LAST_IDX);
   localparam logic [15:0]      c_to_m1  = 16'(IDLE_TIMEOUT - 1);
   localparam logic [15:0]      c_idle_max = 16'hFFFF;

   // ------------------------------------------------------------------------
   // Registers
   // ------------------------------------------------------------------------
   logic [WIDTH-1:0] r_shift;
   logic [CNT_W-1:0] r_bit_cnt;
   logic [15:0]      r_idle;
   logic [AW:0]      r_wr_ptr;
   logic [AW:0]      r_rd_ptr;
   logic [WIDTH-1:0] r_mem [FIFO_DEPTH];
   logic             r_overflow;
   logic             r_timeout;
`ifdef SDRD_PARITY_CHECK_EN
   logic             r_parity_err;
`endif

   // ------------------------------------------------------------------------
   // Combinational wires
   // ------------------------------------------------------------------------
   logic             w_sample;
   logic             w_partial;
   logic             w_complete;
   logic             w_idle_expire;
   logic [WIDTH-1:0] w_shifted;
   logic [WIDTH-1:0] w_word;
   logic [WIDTH-1:0] w_shift_nxt;
   logic [CNT_W-1:0] w_cnt_nxt;
   logic [15:0]      w_idle_nxt;
   logic             w_push;
   logic             w_pop;
   logic             w_full;
   logic             w_empty;
   logic             w_wr_ok;
   logic             w_par_bad;

   // sdrd is tri-stated outside a qualified security-chip read
   assign w_sample   = bus_strobe & ~sser_n & ~ba13 & ba12 & br_w;
   assign w_partial  = (r_bit_cnt != '0);
   assign w_complete = w_sample & (r_bit_cnt == c_last);
   assign w_shifted  = WIDTH'({sdrd, r_shift} >> 1);

   assign w_idle_expire = w_partial & ~w_sample & ~frame_clr & (r_idle == c_to_m1);

`ifdef SDRD_PARITY_CHECK_EN
   // Final sample is the parity bit; data bits are already in place
   assign w_word    = r_shift;
   assign w_par_bad = ~(^{sdrd, r_shift});
`else
   assign w_word    = w_shifted;
   assign w_par_bad = 1'b0;
`endif

   // ------------------------------------------------------------------------
   // Assembly next-state
   // ------------------------------------------------------------------------
   always_comb begin
      w_shift_nxt = r_shift;
      w_cnt_nxt   = r_bit_cnt;
      w_idle_nxt  = r_idle;
      w_push      = 1'b0;
      if (frame_clr) begin
         w_shift_nxt = '0;
         w_cnt_nxt   = '0;
         w_idle_nxt  = '0;
      end else if (w_sample) begin
         w_idle_nxt = '0;
         if (w_complete) begin
            w_push      = 1'b1;
            w_shift_nxt = '0;
            w_cnt_nxt   = '0;
         end else begin
            w_shift_nxt = w_shifted;
            w_cnt_nxt   = r_bit_cnt + 1'b1;
         end
      end else if (w_idle_expire) begin
         w_shift_nxt = '0;
         w_cnt_nxt   = '0;
         w_idle_nxt  = '0;
      end else if (w_partial && (r_idle != c_idle_max)) begin
         w_idle_nxt = r_idle + 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_shift   <= '0;
         r_bit_cnt <= '0;
         r_idle    <= '0;
         r_timeout <= 1'b0;
      end else begin
         r_shift   <= w_shift_nxt;
         r_bit_cnt <= w_cnt_nxt;
         r_idle    <= w_idle_nxt;
         r_timeout <= w_idle_expire;
      end
   end

   // ------------------------------------------------------------------------
   // Completed-word FIFO (extra wrap bit distinguishes full from empty)
   // ------------------------------------------------------------------------
   assign w_empty = (r_wr_ptr == r_rd_ptr);
   assign w_full  = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                    (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
   assign w_pop   = ~w_empty & out_ready;
   // A same-cycle pop frees the slot for a push into a full FIFO
   assign w_wr_ok = w_push & (~w_full | w_pop);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_wr_ptr   <= '0;
         r_rd_ptr   <= '0;
         r_overflow <= 1'b0;
         for (int i = 0; i < FIFO_DEPTH; i++) begin
            r_mem[i] <= '0;
         end
      end else begin
         if (w_pop) begin
            r_rd_ptr <= r_rd_ptr + 1'b1;
         end
         if (w_wr_ok) begin
            r_mem[r_wr_ptr[AW-1:0]] <= w_word;
            r_wr_ptr                <= r_wr_ptr + 1'b1;
         end
         if (w_push && !w_wr_ok) begin
            r_overflow <= 1'b1;
         end
      end
   end

`ifdef SDRD_PARITY_CHECK_EN
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_parity_err <= 1'b0;
      end else begin
         r_parity_err <= w_push & w_par_bad;
      end
   end
   assign parity_err = r_parity_err;
`else
   logic w_unused;
   assign w_unused = w_par_bad;
`endif

   // ------------------------------------------------------------------------
   // Outputs
   // ------------------------------------------------------------------------
   assign out_data    = r_mem[r_rd_ptr[AW-1:0]];
   assign out_valid   = ~w_empty;
   assign bit_cnt     = r_bit_cnt;
   assign overflow    = r_overflow;
   assign timeout_evt = r_timeout;

endmodule

`default_nettype wire

// File: tb/tb_sdrd_byte_assembler.sv
// ============================================================================
// Module   : tb_sdrd_byte_assembler
// Purpose  : Scoreboard bench for sdrd_byte_assembler with a bit-queue model.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_sdrd_byte_assembler;
   localparam int W  = 8;
   localparam int D  = 4;
   localparam int TO = 255;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   logic sser_n = 1'b1, ba13 = 1'b0, ba12 = 1'b0, br_w = 1'b0;
   logic bus_strobe = 1'b0, sdrd = 1'b0, frame_clr = 1'b0, out_ready = 1'b0;
   logic [W-1:0] out_data;
   logic         out_valid;
   logic [3:0]   bit_cnt;
   logic         overflow;
   logic         timeout_evt;

   sdrd_byte_assembler #(.WIDTH(W), .FIFO_DEPTH(D), .IDLE_TIMEOUT(TO)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .sser_n     (sser_n),
      .ba13       (ba13),
      .ba12       (ba12),
      .br_w       (br_w),
      .bus_strobe (bus_strobe),
      .sdrd       (sdrd),
      .frame_clr  (frame_clr),
      .out_data   (out_data),
      .out_valid  (out_valid),
      .out_ready  (out_ready),
      .bit_cnt    (bit_cnt),
      .overflow   (overflow),
      .timeout_evt(timeout_evt)
   );

   always #5 clk = ~clk;

   int total = 0;
   int bad   = 0;

   // Reference model: partial bits as a queue, FIFO as an occupancy count
   bit           bitq[$];
   logic [W-1:0] sb[$];
   int           m_idle = 0;
   int           mcnt   = 0;
   bit           m_ovf  = 0;
   bit           m_to   = 0;
   bit           exp_valid = 0, exp_ovf = 0, exp_to = 0;
   int           exp_bcnt = 0;
   bit           mon_en = 0;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
      end
   endtask

   task automatic model_reset();
      bitq.delete();
      sb.delete();
      m_idle = 0; mcnt = 0; m_ovf = 0; m_to = 0;
      exp_valid = 0; exp_ovf = 0; exp_to = 0; exp_bcnt = 0;
   endtask

   task automatic model_step();
      bit           samp, pop, push;
      logic [W-1:0] word;
      exp_valid = (mcnt > 0);
      exp_bcnt  = bitq.size();
      exp_ovf   = m_ovf;
      exp_to    = m_to;
      samp = bus_strobe && !sser_n && !ba13 && ba12 && br_w;
      pop  = exp_valid && out_ready;
      push = 0;
      word = '0;
      m_to = 0;
      if (frame_clr) begin
         bitq.delete();
         m_idle = 0;
      end else if (samp) begin
         bitq.push_back(sdrd);
         m_idle = 0;
         if (bitq.size() == W) begin
            for (int i = 0; i < W; i++) word[i] = bitq[i];
            push = 1;
            bitq.delete();
         end
      end else if (bitq.size() > 0) begin
         m_idle++;
         if (m_idle >= TO) begin
            bitq.delete();
            m_idle = 0;
            m_to = 1;
         end
      end
      if (pop) mcnt--;
      if (push) begin
         if (mcnt < D) begin
            mcnt++;
            sb.push_back(word);
         end else begin
            m_ovf = 1;
         end
      end
   endtask

   task automatic drive(input bit ss, input bit b13, input bit b12, input bit rw,
                        input bit stb, input bit d, input bit fc, input bit rdy);
      @(negedge clk);
      sser_n = ss; ba13 = b13; ba12 = b12; br_w = rw;
      bus_strobe = stb; sdrd = d; frame_clr = fc; out_ready = rdy;
      #3;
      model_step();
   endtask

   task automatic sample(input bit d, input bit rdy);
      drive(0, 0, 1, 1, 1, d, 0, rdy);
   endtask

   task automatic idle(input int n, input bit rdy);
      for (int i = 0; i < n; i++) drive(1, 0, 0, 0, 0, 0, 0, rdy);
   endtask

   task automatic send_word(input logic [W-1:0] w, input bit rdy);
      for (int i = 0; i < W; i++) sample(w[i], rdy);
   endtask

   task automatic do_reset();
      mon_en = 0;
      @(negedge clk);
      sser_n = 1; bus_strobe = 0; frame_clr = 0; out_ready = 0; sdrd = 0;
      rst_n = 0;
      model_reset();
      @(negedge clk);
      rst_n = 1;
      mon_en = 1;
   endtask

   // Monitor: compares visible DUT state with the model snapshot each cycle
   initial begin
      forever begin
         @(negedge clk);
         #4;
         if (mon_en) begin
            chk("out_valid", out_valid, exp_valid);
            chk("bit_cnt", bit_cnt, exp_bcnt);
            chk("overflow", overflow, exp_ovf);
            chk("timeout_evt", timeout_evt, exp_to);
            if (out_valid && out_ready) begin
               if (sb.size() == 0) chk("sb_underflow", 1, 0);
               else chk("out_data", out_data, sb.pop_front());
            end
         end
      end
   end

   initial begin
      logic [7:0] pat;
      int mode;
      do_reset();
      chk("rst_valid", out_valid, 0);
      chk("rst_bit_cnt", bit_cnt, 0);
      chk("rst_overflow", overflow, 0);
      chk("rst_out_data", out_data, 0);

      // 1,0,1,0,0,1,1,0 LSB first -> 0x65
      pat = 8'h65;
      send_word(pat, 0);
      idle(1, 0);
      chk("word65_data", out_data, 8'h65);
      chk("word65_valid", out_valid, 1);
      chk("word65_bcnt", bit_cnt, 0);
      idle(2, 1);

      // Non-qualified strobes with sdrd=1 interleaved with real samples
      for (int i = 0; i < W; i++) begin
         sample(i[0], 0);
         drive(1, 0, 1, 1, 1, 1, 0, 0);
         drive(0, 0, 0, 1, 1, 1, 0, 0);
         drive(0, 0, 1, 0, 1, 1, 0, 0);
         drive(0, 1, 1, 1, 1, 1, 0, 0);
      end
      idle(3, 1);

      // Fill, then push coincident with pop while full
      do_reset();
      for (int i = 0; i < D; i++) send_word(8'h10 + 8'(i), 0);
      for (int i = 0; i < W - 1; i++) sample(1, 0);
      sample(1, 1);
      idle(1, 0);
      chk("full_pushpop_ovf", overflow, 0);
      idle(6, 1);

      // Overflow: five words with the consumer stalled
      do_reset();
      for (int i = 0; i < 5; i++) send_word(8'hA0 + 8'(i), 0);
      idle(1, 0);
      chk("ovf_after5", overflow, 1);
      idle(6, 1);

      // Idle timeout after 3 samples, then a clean word
      sample(1, 0); sample(1, 0); sample(1, 0);
      idle(TO + 3, 0);
      chk("to_bcnt", bit_cnt, 0);
      send_word(8'h3C, 1);
      idle(3, 1);

      // frame_clr alone and coincident with a completing sample
      for (int i = 0; i < W - 1; i++) sample(1, 1);
      drive(0, 0, 1, 1, 1, 1, 1, 1);
      idle(2, 1);

      // Randomized phase with varying strobe density
      for (int i = 0; i < 4000; i++) begin
         mode = (i / 500) % 3;
         drive($urandom_range(0, 7) == 0, $urandom_range(0, 7) == 0,
               $urandom_range(0, 7) != 0, $urandom_range(0, 7) != 0,
               (mode == 0) ? ($urandom_range(0, 2) == 0) :
               (mode == 1) ? ($urandom_range(0, 199) == 0) : 1'b1,
               1'($urandom), $urandom_range(0, 99) == 0,
               (mode == 2) ? ($urandom_range(0, 3) == 0) : 1'($urandom));
      end
      idle(8, 1);
      chk("sb_empty_end", sb.size(), 0);

      // Asynchronous reset mid-word with two words queued
      do_reset();
      for (int i = 0; i < 5; i++) send_word(8'h50 + 8'(i), 0);
      idle(2, 1);
      sample(1, 0); sample(0, 0);
      idle(1, 0);
      mon_en = 0;
      @(negedge clk);
      #2;
      rst_n = 0;
      #1;
      chk("async_valid", out_valid, 0);
      chk("async_bcnt", bit_cnt, 0);
      chk("async_ovf", overflow, 0);
      model_reset();
      @(negedge clk);
      rst_n = 1;
      mon_en = 1;
      send_word(8'hC3, 0);
      idle(4, 1);

      mon_en = 0;
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule

`default_nettype wire

// File: doc/sdrd_byte_assembler.md
Name: sdrd_byte_assembler

Overview:
- Downstream stage of the CLE381 security-sequencer PAL.
- Samples the SDRD serial bit on every qualified bus read strobe and shifts bits, LSB first, into bytes.
- Buffers completed bytes in a small FIFO that the host-side reader drains through a valid/ready handshake.
- Also tracks frame position and discards partial bytes after bus inactivity.

Parameters:
- WIDTH, 8, bits per assembled word (2..16).
- FIFO_DEPTH, 4, completed-word FIFO entries (power of two, 2..16).
- IDLE_TIMEOUT, 255, clk cycles without a sampled bit before a partial word is discarded (1..65535).

Ports:
- clk  in  1  system clock, all logic on rising edge
- rst_n  in  1  asynchronous active-low reset
- sser_n  in  1  security-chip select, active low, synchronous to clk
- ba13  in  1  bus address bit 13
- ba12  in  1  bus address bit 12
- br_w  in  1  bus read/write, 1 = read
- bus_strobe  in  1  single-cycle pulse marking the end of a bus access
- sdrd  in  1  serial data bit driven by the sequencer PAL
- frame_clr  in  1  synchronous pulse: drop partial word, bit counter to 0
- out_data  out  WIDTH  head-of-FIFO word
- out_valid  out  1  FIFO non-empty
- out_ready  in  1  consumer accepts out_data when out_valid & out_ready
- bit_cnt  out  log2(WIDTH+1)  bits held in the partial word
- overflow  out  1  sticky: a completed word was dropped because the FIFO was full
- timeout_evt  out  1  one-cycle pulse when a partial word is discarded by idle timeout

Behaviour:
- Reset (rst_n=0, async): shift reg=0, bit_cnt=0, FIFO empty, out_valid=0, out_data=0, overflow=0, timeout_evt=0, idle counter=0.
- Sample condition: bus_strobe & ~sser_n & ~ba13 & ba12 & br_w. Only in that cycle is sdrd captured; at all other times sdrd is ignored, because it is tri-stated.
- On sample: shift = {sdrd, shift[WIDTH-1:1]}, so the first bit lands in bit 0 of the final word. bit_cnt increments and the idle counter clears.
- When the sample makes bit_cnt reach WIDTH:
  - The full word is pushed into the FIFO in the same edge.
  - bit_cnt returns to 0.
  - The word is visible on out_data/out_valid one cycle after the sampling edge.
- FIFO push/pop rules:
  - FIFO full at push: word dropped, overflow set (sticky until reset), FIFO contents unchanged.
  - Push and pop in the same cycle with the FIFO full: the pop frees the slot, the push succeeds and overflow is not set.
  - Push and pop in the same cycle with the FIFO empty: out_valid was 0 so no pop occurs; the word appears next cycle.
- Pop: out_valid & out_ready advances the read pointer. out_data is the registered head entry and is stable while out_valid=1 and out_ready=0.
- Idle timeout:
  - The idle counter increments each cycle while 0 < bit_cnt < WIDTH and no sample occurs, saturating.
  - On reaching IDLE_TIMEOUT: bit_cnt=0, shift reg=0, timeout_evt=1 for one cycle, counter clears.
  - The counter does not run while bit_cnt=0.
- frame_clr: bit_cnt=0, shift=0, idle counter=0. The FIFO and overflow are untouched.
  - frame_clr coincident with a sample: frame_clr wins and the bit is discarded.
  - frame_clr coincident with a completing sample: no push.
- Timeout coincident with a sample: the sample wins and the counter clears.
- Reset mid-word or mid-FIFO: all state is lost immediately; no partial output.
- Pointers are log2(FIFO_DEPTH)+1 bits with an extra wrap bit. Full = MSBs differ and the rest are equal.

Optional Feature:
- Macro: SDRD_PARITY_CHECK_EN.
- Defined:
  - A word requires WIDTH+1 samples; the final sample is an odd-parity bit over the WIDTH data bits.
  - Only the data bits are pushed.
  - An extra output parity_err (1 bit) pulses high for one cycle when a completed word fails parity. That word is still pushed.
  - bit_cnt width becomes log2(WIDTH+2).
- Undefined: no parity bit, no parity_err port; exactly WIDTH samples per word.

Test Plan:
- Reset, then 8 qualified samples of sdrd = 1,0,1,0,0,1,1,0 -> one cycle after the 8th sample: out_valid=1, out_data=8'h65, bit_cnt=0.
- Samples with sser_n=1, or ba12=0, or br_w=0 interleaved with valid ones -> only the qualified bits are assembled; a non-qualified sample with sdrd=1 leaves bit_cnt unchanged.
- 5 words pushed with out_ready=0 (FIFO_DEPTH=4) -> out_valid=1, overflow=1 after the 5th. Draining then yields exactly the first 4 words in order, after which out_valid=0.
- 3 samples then 255 idle cycles -> timeout_evt pulses once on the 255th cycle and bit_cnt=0. The next 8 samples form a clean word with no leftover bits.
- FIFO full, then push and pop in the same cycle -> overflow stays 0 and the FIFO stays at 4 entries with the new word at the tail.
- Assert rst_n=0 asynchronously mid-word with 2 words queued -> out_valid and bit_cnt drop to 0 before the next clk edge, and overflow=0.
